// File: rtl/fifo_wr_arb.sv
// ---------------------------------------------------------------------------
// fifo_wr_arb
//
// Round-robin arbiter that shares a single async FIFO write port among
// NUM_REQ producers in the write-clock domain. One requester at a time is
// granted for a burst of up to BURST_LEN words. Accepted words are forwarded
// to the FIFO through registered wr_en/wr_data. The FIFO's write-side
// occupancy provides back-pressure.
//
// Ports:
//   wr_clk     in   FIFO write clock (rising edge)
//   rst_n      in   asynchronous active-low reset
//   req_vld    in   [NUM_REQ]             per-requester word valid
//   req_data   in   [NUM_REQ*DATA_WIDTH]  requester i in [i*DATA_WIDTH +: DATA_WIDTH]
//   req_rdy    out  [NUM_REQ]             per-requester accept (combinational, one-hot or zero)
//   fifo_cnt   in   [ADDR_WIDTH+1]        FIFO write-side occupancy
//   fifo_full  in   FIFO full flag
//   wr_en      out  FIFO write enable (registered)
//   wr_data    out  [DATA_WIDTH]          FIFO write data (registered)
//   grant_id   out  [clog2(NUM_REQ)]      current or most recent grantee
//   busy       out  high while a burst grant is held
// ---------------------------------------------------------------------------
module fifo_wr_arb #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 3,
    parameter int DATA_DEPTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int BURST_LEN  = 4
) (
    input  logic                          wr_clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_vld,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_rdy,
    input  logic [ADDR_WIDTH:0]           fifo_cnt,
    input  logic                          fifo_full,
    output logic                          wr_en,
    output logic [DATA_WIDTH-1:0]         wr_data,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int BW = $clog2(BURST_LEN + 1);
    localparam int CW = ADDR_WIDTH + 2;

    localparam logic [CW-1:0] DEPTH_C   = CW'(DATA_DEPTH);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN);
    localparam logic [GW-1:0] LAST_REQ  = GW'(NUM_REQ - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t                  state, state_nxt;
    logic [GW-1:0]           ptr, ptr_nxt;
    logic [GW-1:0]           grant_nxt;
    logic [BW-1:0]           beat, beat_nxt;
    logic                    wr_en_nxt;
    logic [DATA_WIDTH-1:0]   wr_data_nxt;
    logic [GW:0]             pick;
    logic [GW-1:0]           ptr_after;
    logic [CW-1:0]           occ;
    logic                    space_ok;
    logic                    xfer;
    logic [DATA_WIDTH-1:0]   lane [NUM_REQ];

    // Round-robin search: scan offsets from the highest down to zero so the
    // smallest offset from 'start' is the last one written and wins.
    // The MSB of the result flags that some requester was found.
    function automatic logic [GW:0] pick_next(input logic [NUM_REQ-1:0] vld,
                                              input logic [GW-1:0]      start);
        logic [GW:0] res;
        int          idx;
        res = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = int'(start) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (vld[GW'(idx)]) res = {1'b1, GW'(idx)};
        end
        return res;
    endfunction

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        assign lane[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // The write issued last cycle is not yet reflected in fifo_cnt, so it is
    // added in before comparing against the depth.
    assign occ      = CW'(fifo_cnt) + CW'(wr_en);
    assign space_ok = !fifo_full && (occ < DEPTH_C);

    assign ptr_after = (grant_id == LAST_REQ) ? '0 : grant_id + 1'b1;
    assign busy      = (state == BURST);

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        beat_nxt    = beat;
        grant_nxt   = grant_id;
        wr_en_nxt   = 1'b0;
        wr_data_nxt = wr_data;
        req_rdy     = '0;
        xfer        = 1'b0;
        pick        = pick_next(req_vld, ptr);

        case (state)
            IDLE: begin
                if (pick[GW]) begin
                    grant_nxt = pick[GW-1:0];
                    beat_nxt  = '0;
                    state_nxt = BURST;
                end
            end
            BURST: begin
                req_rdy[grant_id] = space_ok;
                xfer              = req_vld[grant_id] && space_ok;
                if (xfer) begin
                    beat_nxt    = beat + 1'b1;
                    wr_en_nxt   = 1'b1;
                    wr_data_nxt = lane[grant_id];
                    if (beat_nxt == LAST_BEAT) begin
                        state_nxt = IDLE;
                        ptr_nxt   = ptr_after;
                    end
                end else if (!req_vld[grant_id]) begin
                    // Requester dropped out: give up the rest of the burst.
                    state_nxt = IDLE;
                    ptr_nxt   = ptr_after;
                end
                // Otherwise back-pressured: keep the grant and wait.
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            beat     <= '0;
            grant_id <= '0;
            wr_en    <= 1'b0;
            wr_data  <= '0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            beat     <= beat_nxt;
            grant_id <= grant_nxt;
            wr_en    <= wr_en_nxt;
            wr_data  <= wr_data_nxt;
        end
    end

endmodule
